// File: rtl/audio_level_meter_if.sv
// Sample-stream and level-report signals between the audio source, the meter
// and the PicoBlaze controller.
interface audio_level_meter_if;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic               meter_en;
    logic        [7:0]  level_out;
    logic               level_irq;
    logic               clip_flag;

    modport master (
        output sample_in, sample_valid, meter_en,
        input  level_out, level_irq, clip_flag
    );

    modport slave (
        input  sample_in, sample_valid, meter_en,
        output level_out, level_irq, clip_flag
    );
endinterface

// File: rtl/audio_level_meter.sv
// Windowed peak/clip meter feeding the volume controller.
// Optional peak-hold with decay is enabled by defining PEAK_DECAY_EN.
module audio_level_meter #(
    parameter int WINDOW_SAMPLES = 1024,
    parameter int CLIP_THRESH    = 32000,
    parameter int DECAY_STEP     = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    audio_level_meter_if.slave  bus
);

    localparam logic [15:0] LAST_CNT = 16'(WINDOW_SAMPLES - 1);
    localparam logic [14:0] CLIP_LIM = 15'(CLIP_THRESH);

    // Magnitude of a two's-complement sample; -32768 clamps to full scale.
    function automatic logic [14:0] abs_sat(input logic signed [15:0] s);
        if (s[15] && (s[14:0] == 15'd0)) return 15'h7FFF;
        else if (s[15])                  return 15'(-s);
        else                             return s[14:0];
    endfunction

    function automatic logic [7:0] decay_sat(input logic [7:0] lvl);
        logic [8:0] step;
        step = 9'(DECAY_STEP);
        if ({1'b0, lvl} >= step) return lvl - step[7:0];
        else                     return 8'd0;
    endfunction

    logic               accept;
    logic        [15:0] win_cnt_q, win_cnt_d;
    logic               vld_p1_q, vld_p1_d;
    logic        [14:0] mag_p1_q, mag_p1_d;
    logic               last_p1_q, last_p1_d;
    logic               clip_p1_q, clip_p1_d;
    logic        [14:0] peak_q, peak_d;
    logic               clip_acc_q, clip_acc_d;
    logic        [14:0] pk;
    logic               cl;
    logic               vld_p2_q, vld_p2_d;
    logic        [7:0]  level_p2_q, level_p2_d;
    logic               clip_p2_q, clip_p2_d;
    logic        [7:0]  level_out_q, level_out_d;
    logic               level_irq_q, level_irq_d;
    logic               clip_flag_q, clip_flag_d;

    // ---- stage 1: accept, magnitude, window position ----
    always_comb begin
        accept    = bus.sample_valid & bus.meter_en;
        win_cnt_d = win_cnt_q;
        vld_p1_d  = accept;
        mag_p1_d  = mag_p1_q;
        last_p1_d = last_p1_q;
        clip_p1_d = clip_p1_q;
        if (accept) begin
            win_cnt_d = (win_cnt_q == LAST_CNT) ? 16'd0 : win_cnt_q + 16'd1;
            mag_p1_d  = abs_sat(bus.sample_in);
            last_p1_d = (win_cnt_q == LAST_CNT);
            clip_p1_d = (abs_sat(bus.sample_in) >= CLIP_LIM);
        end
    end

    // ---- stage 2: peak/clip accumulation and window close ----
    always_comb begin
        pk         = (mag_p1_q > peak_q) ? mag_p1_q : peak_q;
        cl         = clip_acc_q | clip_p1_q;
        peak_d     = peak_q;
        clip_acc_d = clip_acc_q;
        vld_p2_d   = 1'b0;
        level_p2_d = level_p2_q;
        clip_p2_d  = clip_p2_q;
        if (vld_p1_q) begin
            if (last_p1_q) begin
                // Closing sample is folded in; the accumulators restart clean.
                vld_p2_d   = 1'b1;
                level_p2_d = pk[14:7];
                clip_p2_d  = cl;
                peak_d     = 15'd0;
                clip_acc_d = 1'b0;
            end else begin
                peak_d     = pk;
                clip_acc_d = cl;
            end
        end
    end

    // ---- output stage: level/clip update and interrupt pulse ----
    always_comb begin
        level_out_d = level_out_q;
        clip_flag_d = clip_flag_q;
        level_irq_d = vld_p2_q;
        if (vld_p2_q) begin
`ifdef PEAK_DECAY_EN
            level_out_d = (level_p2_q > decay_sat(level_out_q)) ? level_p2_q
                                                                 : decay_sat(level_out_q);
`else
            level_out_d = level_p2_q;
`endif
            clip_flag_d = clip_p2_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt_q   <= 16'd0;
            vld_p1_q    <= 1'b0;
            peak_q      <= 15'd0;
            clip_acc_q  <= 1'b0;
            vld_p2_q    <= 1'b0;
            level_out_q <= 8'd0;
            level_irq_q <= 1'b0;
            clip_flag_q <= 1'b0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            vld_p1_q    <= vld_p1_d;
            peak_q      <= peak_d;
            clip_acc_q  <= clip_acc_d;
            vld_p2_q    <= vld_p2_d;
            level_out_q <= level_out_d;
            level_irq_q <= level_irq_d;
            clip_flag_q <= clip_flag_d;
        end
    end

    // Data-only pipeline registers; only consumed when their valid is set.
    always_ff @(posedge clk) begin
        mag_p1_q   <= mag_p1_d;
        last_p1_q  <= last_p1_d;
        clip_p1_q  <= clip_p1_d;
        level_p2_q <= level_p2_d;
        clip_p2_q  <= clip_p2_d;
    end

    assign bus.level_out = level_out_q;
    assign bus.level_irq = level_irq_q;
    assign bus.clip_flag = clip_flag_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Directed bench for audio_level_meter with a 4-sample window.
// Define PEAK_DECAY_EN for both files to exercise the decay build.
module tb_audio_level_meter;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   irq_cnt;
    int   irq_base;

    audio_level_meter_if bus();

    audio_level_meter #(
        .WINDOW_SAMPLES(4),
        .CLIP_THRESH   (32000),
        .DECAY_STEP    (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

`ifdef PEAK_DECAY_EN
    localparam logic [7:0] EXP_ZERO = 8'hFB;
    localparam logic [7:0] EXP_THLO = 8'hF9;
    localparam logic [7:0] EXP_THHI = 8'hFA;
    localparam logic [7:0] EXP_GATE = 8'hF6;
`else
    localparam logic [7:0] EXP_ZERO = 8'h00;
    localparam logic [7:0] EXP_THLO = 8'hF9;
    localparam logic [7:0] EXP_THHI = 8'hFA;
    localparam logic [7:0] EXP_GATE = 8'h04;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.level_irq === 1'b1) irq_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] s);
        @(negedge clk);
        bus.sample_in    = s;
        bus.sample_valid = 1'b1;
    endtask

    // After the 4th send: irq is low one cycle after the accept edge,
    // then high with the new level two edges after it.
    task automatic close_check(input string tag, input logic [7:0] lvl, input logic clp);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        chk({tag, "_irq_e1"}, 32'(bus.level_irq), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_irq_e2"}, 32'(bus.level_irq), 32'd1);
        chk({tag, "_level"}, 32'(bus.level_out), 32'(lvl));
        chk({tag, "_clip"}, 32'(bus.clip_flag), 32'(clp));
        @(negedge clk);
        chk({tag, "_irq_e3"}, 32'(bus.level_irq), 32'd0);
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        irq_cnt          = 0;
        bus.sample_in    = 16'h0000;
        bus.sample_valid = 1'b0;
        bus.meter_en     = 1'b1;
        reset_n          = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_level", 32'(bus.level_out), 32'd0);
        chk("rst_irq", 32'(bus.level_irq), 32'd0);
        chk("rst_clip", 32'(bus.clip_flag), 32'd0);
        reset_n = 1'b1;

        repeat (5000) @(negedge clk);
        chk("idle_irqs", 32'(irq_cnt), 32'd0);
        chk("idle_level", 32'(bus.level_out), 32'd0);
        chk("idle_clip", 32'(bus.clip_flag), 32'd0);

        // Peak 256 -> level 2; mixed signs, back-to-back.
        send(16'h0100); send(16'hFF00); send(16'h0080); send(16'h0040);
        close_check("basic", 8'h02, 1'b0);
        chk("basic_irqs", 32'(irq_cnt), 32'd1);

        send(16'h8000); send(16'h0000); send(16'h0000); send(16'h0000);
        close_check("sat", 8'hFF, 1'b1);
        send(16'h0000); send(16'h0000); send(16'h0000); send(16'h0000);
        close_check("zero", EXP_ZERO, 1'b0);

        // Clip threshold boundaries: 31999 below, -32000 at threshold.
        send(16'h7CFF); send(16'h0000); send(16'h0000); send(16'h0000);
        close_check("th_lo", EXP_THLO, 1'b0);
        send(16'h8300); send(16'h0000); send(16'h0000); send(16'h0000);
        close_check("th_hi", EXP_THHI, 1'b1);

        // Gated strobes of full-scale must not reach the window.
        irq_base = irq_cnt;
        send(16'h0200); send(16'h0000);
        @(negedge clk);
        bus.meter_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.sample_in    = 16'h7FFF;
            bus.sample_valid = 1'b1;
            @(negedge clk);
        end
        bus.sample_valid = 1'b0;
        chk("gate_noirq", 32'(irq_cnt - irq_base), 32'd0);
        bus.meter_en = 1'b1;
        send(16'h0100); send(16'h0000);
        close_check("gate", EXP_GATE, 1'b0);
        chk("gate_irqs", 32'(irq_cnt - irq_base), 32'd1);

        // Reset mid-window discards the partial window.
        send(16'h7FFF); send(16'h7FFF); send(16'h7FFF);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_level", 32'(bus.level_out), 32'd0);
        reset_n  = 1'b1;
        irq_base = irq_cnt;
        repeat (4) @(negedge clk);
        chk("midrst_noirq", 32'(irq_cnt - irq_base), 32'd0);
        send(16'h0000); send(16'h0000); send(16'h0000); send(16'h0000);
        close_check("midrst", 8'h00, 1'b0);
        repeat (10) @(negedge clk);
        chk("midrst_irqs", 32'(irq_cnt - irq_base), 32'd1);

`ifdef PEAK_DECAY_EN
        send(16'h7FFF); send(16'h0000); send(16'h0000); send(16'h0000);
        close_check("dec0", 8'hFF, 1'b1);
        send(16'h0000); send(16'h0000); send(16'h0000); send(16'h0000);
        close_check("dec1", 8'hFB, 1'b0);
        send(16'h0000); send(16'h0000); send(16'h0000); send(16'h0000);
        close_check("dec2", 8'hF7, 1'b0);
        for (int w = 0; w < 64; w++) begin
            send(16'h0000); send(16'h0000); send(16'h0000); send(16'h0000);
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("dec_floor", 32'(bus.level_out), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
